// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: stack/queue command sequencer for a 32-entry calculator memory.
// Latency (accept edge -> done): PUSH 2, POP 3, ADD/SUB/AND/OR 7, CLEAR 1, any error 1.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid while busy is simply not accepted.
// Ports: clk/rst (async, active-high); command side mode_queue, cmd_valid/cmd_ready,
//   cmd_op, cmd_data; memory side mem_we, mem_addr, mem_wdata, mem_rdata (sync read,
//   one-cycle latency); status result, done, err, count, empty, full.
module calc_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_queue,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD1W, S_RD2, S_RD2W, S_EXEC, S_WR, S_DONE
  } state_t;

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_POP   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   head_q, head_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [2:0]          op_q, op_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [ADDR_W-1:0]   cnt_lo;
  logic [ADDR_W-1:0]   first_addr_new;  // first operand, mode taken from the incoming command
  logic [ADDR_W-1:0]   second_addr;     // second operand, mode latched at accept
  logic [ADDR_W-1:0]   exec_head;
  logic [ADDR_W:0]     exec_count;
  logic [DATA_W-1:0]   alu;

  // Addresses wrap mod DEPTH by truncation to ADDR_W bits.
  assign cnt_lo         = count_q[ADDR_W-1:0];
  assign first_addr_new = mode_queue ? head_q : head_q + cnt_lo - ADDR_W'(1);
  assign second_addr    = mode_q ? head_q + ADDR_W'(1) : head_q + cnt_lo - ADDR_W'(2);
  // Pointer state after both operands are consumed; the write-back lands at exec_head+exec_count.
  assign exec_head      = mode_q ? head_q + ADDR_W'(2) : head_q;
  assign exec_count     = count_q - (ADDR_W+1)'(2);

  always_comb begin
    alu = opa_q + opb_q;
    case (op_q)
      OP_SUB:  alu = opa_q - opb_q;
      OP_AND:  alu = opa_q & opb_q;
      OP_OR:   alu = opa_q | opb_q;
      default: alu = opa_q + opb_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    count_d  = count_q;
    op_d     = op_q;
    mode_d   = mode_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          mode_d = mode_queue;
          case (cmd_op)
            OP_PUSH: begin
              if (count_q == CNT_FULL) begin
                state_d = S_DONE; done_d = 1'b1; err_d = 1'b1;
              end else begin
                opa_d   = cmd_data;
                wdata_d = cmd_data;
                addr_d  = head_q + cnt_lo;
                we_d    = 1'b1;
                state_d = S_WR;
              end
            end
            OP_POP: begin
              if (count_q == '0) begin
                state_d = S_DONE; done_d = 1'b1; err_d = 1'b1;
              end else begin
                addr_d  = first_addr_new;
                state_d = S_RD1;
              end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              if (count_q < (ADDR_W+1)'(2)) begin
                state_d = S_DONE; done_d = 1'b1; err_d = 1'b1;
              end else begin
                addr_d  = first_addr_new;
                state_d = S_RD1;
              end
            end
            OP_CLEAR: begin
              head_d  = '0;
              count_d = '0;
              state_d = S_DONE;
              done_d  = 1'b1;
            end
            default: begin
              state_d = S_DONE; done_d = 1'b1; err_d = 1'b1;
            end
          endcase
        end
      end
      S_RD1: state_d = S_RD1W;
      S_RD1W: begin
        opa_d = mem_rdata;
        if (op_q == OP_POP) begin
          result_d = mem_rdata;
          count_d  = count_q - (ADDR_W+1)'(1);
          if (mode_q) head_d = head_q + ADDR_W'(1);
          state_d  = S_DONE;
          done_d   = 1'b1;
        end else begin
          addr_d  = second_addr;
          state_d = S_RD2;
        end
      end
      S_RD2:  state_d = S_RD2W;
      S_RD2W: begin
        opb_d   = mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        head_d  = exec_head;
        count_d = exec_count;
        wdata_d = alu;
        addr_d  = exec_head + exec_count[ADDR_W-1:0];
        we_d    = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        count_d  = count_q + (ADDR_W+1)'(1);
        result_d = wdata_q;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      head_q   <= '0;
      count_q  <= '0;
      op_q     <= '0;
      mode_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      count_q  <= count_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign result    = result_q;
  assign done      = done_q;
  assign err       = err_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode_queue;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] result;
  logic          done;
  logic          err;
  logic [AW:0]   count;
  logic          empty;
  logic          full;

  calc_op_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .mode_queue(mode_queue), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .result(result),
    .done(done), .err(err), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Synchronous memory array the sequencer drives.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: logical contents in order from the head, plus the head pointer.
  logic [DW-1:0] model_q[$];
  int            m_head = 0;
  logic [DW-1:0] m_result = '0;

  task automatic model_reset();
    model_q.delete();
    m_head = 0;
    m_result = '0;
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [DW-1:0] d, input bit qm,
                           output bit e_err, output int e_lat, output int e_nwr,
                           output int e_waddr, output logic [DW-1:0] e_wdata);
    logic [DW-1:0] a, b, r;
    e_err = 0; e_lat = 1; e_nwr = 0; e_waddr = 0; e_wdata = '0;
    case (op)
      3'd0: begin
        if (model_q.size() == DEPTH) e_err = 1;
        else begin
          e_waddr = (m_head + model_q.size()) % DEPTH;
          e_wdata = d; e_nwr = 1; e_lat = 2;
          model_q.push_back(d);
          m_result = d;
        end
      end
      3'd5: begin
        if (model_q.size() == 0) e_err = 1;
        else begin
          e_lat = 3;
          if (qm) begin
            m_result = model_q.pop_front();
            m_head = (m_head + 1) % DEPTH;
          end else m_result = model_q.pop_back();
        end
      end
      3'd1, 3'd2, 3'd3, 3'd4: begin
        if (model_q.size() < 2) e_err = 1;
        else begin
          if (qm) begin
            a = model_q.pop_front();
            b = model_q.pop_front();
            m_head = (m_head + 2) % DEPTH;
          end else begin
            a = model_q.pop_back();
            b = model_q.pop_back();
          end
          case (op)
            3'd1: r = a + b;
            3'd2: r = a - b;
            3'd3: r = a & b;
            default: r = a | b;
          endcase
          e_waddr = (m_head + model_q.size()) % DEPTH;
          e_wdata = r; e_nwr = 1; e_lat = 7;
          model_q.push_back(r);
          m_result = r;
        end
      end
      3'd6: begin
        model_q.delete();
        m_head = 0;
      end
      default: e_err = 1;
    endcase
  endtask

  // Issue one command, then watch until done (bounded) recording any memory writes.
  task automatic run_cmd(input logic [2:0] op, input logic [DW-1:0] d, input bit qm,
                         output bit g_done, output bit g_err, output int g_lat,
                         output int g_nwr, output int g_waddr, output logic [DW-1:0] g_wdata);
    int n;
    g_done = 0; g_err = 0; g_lat = 0; g_nwr = 0; g_waddr = 0; g_wdata = '0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_op = op; cmd_data = d; mode_queue = qm; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (g_lat < 20 && !g_done) begin
      g_lat++;
      @(negedge clk);
      if (mem_we) begin
        g_nwr++; g_waddr = int'(mem_addr); g_wdata = mem_wdata;
      end
      if (done) begin
        g_done = 1; g_err = err;
      end else @(posedge clk);
    end
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [DW-1:0] d, input bit qm);
    bit e_err, g_done, g_err;
    int e_lat, e_nwr, e_waddr, g_lat, g_nwr, g_waddr;
    logic [DW-1:0] e_wdata, g_wdata;
    model_cmd(op, d, qm, e_err, e_lat, e_nwr, e_waddr, e_wdata);
    run_cmd(op, d, qm, g_done, g_err, g_lat, g_nwr, g_waddr, g_wdata);
    chk({tag, ".done"}, g_done, 1);
    chk({tag, ".err"}, g_err, e_err);
    if (g_done) chk({tag, ".latency"}, g_lat, e_lat);
    chk({tag, ".writes"}, g_nwr, e_nwr);
    if (e_nwr == 1 && g_nwr == 1) begin
      chk({tag, ".waddr"}, g_waddr, e_waddr);
      chk({tag, ".wdata"}, g_wdata, e_wdata);
    end
    chk({tag, ".result"}, result, m_result);
    chk({tag, ".count"}, count, model_q.size());
    chk({tag, ".empty"}, empty, model_q.size() == 0);
    chk({tag, ".full"}, full, model_q.size() == DEPTH);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] d;
    bit            qm;
    bit            e_err;
    int            e_lat;
    logic [DW-1:0] e_res;
    int            e_cnt;
    int            e_nwr;
    int            e_waddr;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t tbl[12];
  logic [DW-1:0] orig[DEPTH];

  initial begin
    bit m_err, g_done, g_err;
    int m_lat, m_nwr, m_waddr, g_lat, g_nwr, g_waddr, accepts, n;
    logic [DW-1:0] m_wdata, g_wdata;
    logic [2:0] op;
    int r;

    //         op    data          qm err lat res           cnt nwr waddr wdata
    tbl[0]  = '{3'd5, 32'd0,        1, 1, 1, 32'd0,        0,  0,  0,   32'd0};
    tbl[1]  = '{3'd7, 32'd0,        1, 1, 1, 32'd0,        0,  0,  0,   32'd0};
    tbl[2]  = '{3'd1, 32'd0,        1, 1, 1, 32'd0,        0,  0,  0,   32'd0};
    tbl[3]  = '{3'd0, 32'd10,       1, 0, 2, 32'd10,       1,  1,  0,   32'd10};
    tbl[4]  = '{3'd0, 32'd3,        1, 0, 2, 32'd3,        2,  1,  1,   32'd3};
    tbl[5]  = '{3'd0, 32'd7,        1, 0, 2, 32'd7,        3,  1,  2,   32'd7};
    tbl[6]  = '{3'd2, 32'd0,        1, 0, 7, 32'd7,        2,  1,  3,   32'd7};
    tbl[7]  = '{3'd5, 32'd0,        1, 0, 3, 32'd7,        1,  0,  0,   32'd0};
    tbl[8]  = '{3'd3, 32'd0,        1, 1, 1, 32'd7,        1,  0,  0,   32'd0};
    tbl[9]  = '{3'd0, 32'hFFFFFFFF, 0, 0, 2, 32'hFFFFFFFF, 2,  1,  4,   32'hFFFFFFFF};
    tbl[10] = '{3'd4, 32'd0,        0, 0, 7, 32'hFFFFFFFF, 1,  1,  3,   32'hFFFFFFFF};
    tbl[11] = '{3'd6, 32'd0,        0, 0, 1, 32'hFFFFFFFF, 0,  0,  0,   32'd0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; mode_queue = 1'b0;
    #2;
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.result", result, 0);
    chk("rst.cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Directed table: errors on empty, queue SUB, mixed-mode ops, CLEAR.
    for (int i = 0; i < 12; i++) begin
      model_cmd(tbl[i].op, tbl[i].d, tbl[i].qm, m_err, m_lat, m_nwr, m_waddr, m_wdata);
      run_cmd(tbl[i].op, tbl[i].d, tbl[i].qm, g_done, g_err, g_lat, g_nwr, g_waddr, g_wdata);
      chk($sformatf("tbl%0d.done", i), g_done, 1);
      chk($sformatf("tbl%0d.err", i), g_err, tbl[i].e_err);
      chk($sformatf("tbl%0d.latency", i), g_lat, tbl[i].e_lat);
      chk($sformatf("tbl%0d.result", i), result, tbl[i].e_res);
      chk($sformatf("tbl%0d.count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d.writes", i), g_nwr, tbl[i].e_nwr);
      if (tbl[i].e_nwr == 1) begin
        chk($sformatf("tbl%0d.waddr", i), g_waddr, tbl[i].e_waddr);
        chk($sformatf("tbl%0d.wdata", i), g_wdata, tbl[i].e_wdata);
      end
    end

    // Stack fill to full, overflow, ADD chain down to one entry, then underflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_cmd($sformatf("fill%0d", i), 3'd0, DW'(i + 1), 1'b0);
    chk("fill.full", full, 1);
    do_cmd("push_full", 3'd0, 32'd99, 1'b0);
    chk("push_full.count", count, 32);
    for (int i = 0; i < DEPTH - 1; i++) do_cmd($sformatf("add%0d", i), 3'd1, 32'd0, 1'b0);
    chk("addchain.result", result, 528);
    chk("addchain.count", count, 1);
    do_cmd("add_underflow", 3'd1, 32'd0, 1'b0);

    // Queue wrap-around.
    do_cmd("wrap.clear", 3'd6, 32'd0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      orig[i] = $urandom;
      do_cmd("wrap.push", 3'd0, orig[i], 1'b1);
    end
    for (int i = 0; i < 30; i++) do_cmd("wrap.pop", 3'd5, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) do_cmd($sformatf("wrap.push2_%0d", i), 3'd0, $urandom, 1'b1);
    chk("wrap.count", count, 7);
    chk("wrap.full", full, 0);
    do_cmd("wrap.pop31", 3'd5, 32'd0, 1'b1);
    chk("wrap.pop31.value", result, orig[30]);

    // cmd_valid held high across a whole ADD: exactly one accept.
    model_cmd(3'd1, 32'd0, 1'b1, m_err, m_lat, m_nwr, m_waddr, m_wdata);
    @(negedge clk);
    cmd_op = 3'd1; cmd_data = '0; mode_queue = 1'b1; cmd_valid = 1'b1;
    accepts = 0; n = 0; g_done = 0;
    while (n < 20 && !g_done) begin
      if (cmd_valid && cmd_ready) accepts++;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (done) begin
        g_done = 1;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    chk("held.accepts", accepts, 1);
    chk("held.latency", n, 7);
    chk("held.result", result, m_result);
    chk("held.count", count, model_q.size());

    // Randomized commands against the reference model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < ((i < 200) ? 60 : 30)) op = 3'd0;
      else if (r < 75) op = 3'd5;
      else if (r < 95) op = 3'($urandom_range(1, 4));
      else if (r < 97) op = 3'd6;
      else op = 3'd7;
      do_cmd($sformatf("rnd%0d", i), op, $urandom, 1'($urandom_range(0, 1)));
    end

    // Async reset in RD2W of an ADD.
    do_cmd("ar.push0", 3'd0, 32'd5, 1'b0);
    do_cmd("ar.push1", 3'd0, 32'd6, 1'b0);
    do_cmd("ar.push2", 3'd0, 32'd7, 1'b0);
    @(negedge clk);
    cmd_op = 3'd1; mode_queue = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar.mem_we", mem_we, 0);
    chk("ar.done", done, 0);
    chk("ar.count", count, 0);
    chk("ar.result", result, 0);
    chk("ar.cmd_ready", cmd_ready, 1);
    g_nwr = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_we || done) g_nwr++;
    end
    rst = 1'b0;
    model_reset();
    repeat (10) begin
      @(negedge clk);
      if (mem_we || done) g_nwr++;
    end
    chk("ar.no_activity", g_nwr, 0);
    chk("ar.ready_after", cmd_ready, 1);
    do_cmd("ar.pop_empty", 3'd5, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Command sequencer for the 32-entry calculator memory, usable as a stack (LIFO) or a queue (FIFO).
- Accepts one command at a time: PUSH, POP, CLEAR, or a binary ALU op (ADD/SUB/AND/OR).
- Drives the memory port through a multi-state FSM: read operand(s), compute, write back, report.
- Sits between button/switch decode and the memory array; `result` feeds the seven-segment path.

Parameters:
DATA_W, 32, data word width
DEPTH, 32, number of memory entries (power of two)
ADDR_W, 5, log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
mode_queue  in  1  0 = stack, 1 = queue; sampled at command accept
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at a clk edge
cmd_op  in  3  000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 POP, 110 CLEAR, 111 reserved
cmd_data  in  DATA_W  PUSH operand
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous read data, valid the cycle after mem_addr is presented
result  out  DATA_W  last pushed, popped or computed value
done  out  1  one-cycle completion pulse
err  out  1  high only together with done; command rejected, no state change
count  out  ADDR_W+1  occupied entries, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH

Behaviour:
- Storage model: head pointer (ADDR_W) plus count. All addresses are computed mod DEPTH.
  - Push address, both modes: head+count.
  - Stack pops: top = head+count-1, then head+count-2.
  - Queue pops: head, then head+1; head advances by one per pop.
  - mode_queue may change between commands with data present; the unified pointers keep this legal.
- Reset (async): FSM to IDLE, head=0, count=0, result=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, internal operand registers 0. Memory contents are not touched.
- Reset mid-command aborts immediately. No memory write occurs after rst rises.
- FSM states: IDLE, RD1, RD1W, RD2, RD2W, EXEC, WR, DONE. Outputs are registered/Moore.
- IDLE (cmd_ready=1), on accept:
  - PUSH: if full, go to DONE with err; else latch cmd_data and go to WR.
  - POP: if empty, go to DONE with err; else go to RD1.
  - ADD/SUB/AND/OR: if count<2, go to DONE with err; else go to RD1.
  - CLEAR: head=0, count=0, go to DONE.
  - 111: go to DONE with err.
- RD1: mem_addr = first-operand address, then RD1W.
- RD1W: opA <= mem_rdata.
  - POP: result=opA, count-1, queue head+1; go to DONE.
  - Binary op: go to RD2.
- RD2: mem_addr = second-operand address, then RD2W. RD2W: opB <= mem_rdata, then EXEC.
- EXEC: compute result.
  - ADD = opA+opB; SUB = opA-opB (opA is the first read); AND/OR bitwise.
  - Arithmetic is modulo 2^DATA_W; no overflow flag.
  - count-2; queue head+2. Then WR.
- WR: mem_we=1 for exactly one cycle, mem_addr = head+count (post-pop values), mem_wdata = pushed value or result. count+1, result updated, then DONE.
- DONE: done=1 for one cycle (err if rejected), then IDLE.
- Latency, accept edge to done-high cycle: PUSH 2, POP 3, binary 7, CLEAR 1, any error 1.
- cmd_valid while busy is ignored; the command is accepted only when IDLE returns.
- A binary op on a full memory is legal (net count -1).
- Pointer wrap DEPTH-1 -> 0 is seamless.
- A rejected command leaves head, count, result and memory unchanged.

Test Plan:
- Stack fill: rst, mode_queue=0, PUSH 1..32 -> each done 2 cycles after accept, mem[i]=i+1, full=1 after 32nd; 33rd PUSH -> err=1, count stays 32.
- Stack ADD chain on the full stack:
  - First ADD reads addr 31 (32), then 30 (31); writes 63 to addr 30; count=31; done 7 cycles after accept.
  - 31 ADDs total -> result=528, count=1.
  - 32nd ADD -> err, count 1.
- Queue SUB: CLEAR, mode_queue=1, PUSH 10,3,7 -> SUB writes 7 to addr 3, head=2, count=2. POP -> result=7, head=3, count=1.
- Queue wrap: CLEAR, PUSH 32 values, POP 30, PUSH 5 -> writes at addrs 0..4, count=7, full=0. Then POP returns the 31st original value.
- Errors:
  - POP when empty -> done+err 1 cycle after accept.
  - cmd_op=111 -> err.
  - cmd_valid held high during a 7-cycle ADD -> exactly one command accepted.
- Async reset: assert rst in RD2W of an ADD -> same cycle mem_we=0, done=0, count=0, result=0; no write follows; cmd_ready=1 after rst falls.
